// File: rtl/result_tile_writer.sv
// Write-back stage of the 4x4 tiled matrix multiplier: stores the in-bounds part of a
// result tile into C and posts the status word on the last tile. Optional macro: ACCUMULATE_EN.
module result_tile_writer #(
  parameter int ADDRESS_SIZE = 9,
  parameter int STATUS_ADDR  = 0,
  parameter int C_OFFSET     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tile_stb,
  output logic                    tile_ack,
  input  logic [511:0]            tile_data,
  input  logic [7:0]              tile_row_index,
  input  logic [7:0]              tile_col_index,
  input  logic                    last_tile,
  input  logic [7:0]              C_row_size,
  input  logic [7:0]              C_column_size,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [31:0]             mem_Din,
  output logic                    mem_read,
  output logic                    mem_write,
  input  logic [31:0]             mem_Dout,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WRITE  = 3'd2,
    S_STATUS = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [1:0]              i_r, j_r, i_s, j_s;
  logic [511:0]            tile_r;
  logic [7:0]              row_r, col_r, nrows_r, ncols_r;
  logic                    last_r;
  logic                    cap_s;

  logic                    tile_ack_r, tile_ack_s;
  logic [ADDRESS_SIZE-1:0] mem_addr_r, mem_addr_s;
  logic [31:0]             mem_din_r, mem_din_s;
  logic                    mem_read_r, mem_read_s;
  logic                    mem_write_r, mem_write_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;

  logic [15:0]             row_sum_s, col_sum_s, addr_full_s;
  logic                    in_bounds_s, col_wrap_s, row_end_s;
  logic [1:0]              adv_i_s, adv_j_s;
  logic                    adv_done_s;
  logic [31:0]             elem_s;
  state_t                  fin_state_s;

  // Position arithmetic for the current (i,j), done in 16 bits.
  assign row_sum_s   = {8'd0, row_r} + {14'd0, i_r};
  assign col_sum_s   = {8'd0, col_r} + {14'd0, j_r};
  assign in_bounds_s = (row_sum_s < {8'd0, nrows_r}) && (col_sum_s < {8'd0, ncols_r});
  assign col_wrap_s  = (j_r == 2'd3) || ((col_sum_s + 16'd1) >= {8'd0, ncols_r});
  assign row_end_s   = (i_r == 2'd3) || ((row_sum_s + 16'd1) >= {8'd0, nrows_r});
  assign addr_full_s = row_sum_s * {8'd0, ncols_r} + col_sum_s + 16'(C_OFFSET);
  assign elem_s      = tile_r[{i_r, j_r, 5'd0} +: 32];

  assign adv_j_s     = col_wrap_s ? 2'd0 : j_r + 2'd1;
  assign adv_i_s     = col_wrap_s ? i_r + 2'd1 : i_r;
  assign adv_done_s  = col_wrap_s && row_end_s;
  assign fin_state_s = last_r ? S_STATUS : S_DONE;

`ifdef ACCUMULATE_EN
  logic acc_r, acc_s;
`endif

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    state_s     = state_r;
    i_s         = i_r;
    j_s         = j_r;
    cap_s       = 1'b0;
    tile_ack_s  = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_din_s   = mem_din_r;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    busy_s      = busy_r;
    done_s      = 1'b0;
`ifdef ACCUMULATE_EN
    acc_s       = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (tile_stb) begin
          cap_s      = 1'b1;
          tile_ack_s = 1'b1;
          busy_s     = 1'b1;
          i_s        = 2'd0;
          j_s        = 2'd0;
`ifdef ACCUMULATE_EN
          state_s    = S_RD;
`else
          state_s    = S_WRITE;
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
`ifdef ACCUMULATE_EN
      S_RD: begin
        if (in_bounds_s) begin
          mem_read_s = 1'b1;
          mem_addr_s = addr_full_s[ADDRESS_SIZE-1:0];
          state_s    = S_WRITE;
        end else if (last_r) begin
          // Only (0,0) can be out of bounds here: leave without touching C.
          mem_write_s = 1'b1;
          mem_addr_s  = ADDRESS_SIZE'(STATUS_ADDR);
          mem_din_s   = 32'h0000_0002;
          state_s     = S_DONE;
        end else begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = S_IDLE;
        end
      end
      S_WRITE: begin
        mem_write_s = 1'b1;
        mem_addr_s  = addr_full_s[ADDRESS_SIZE-1:0];
        mem_din_s   = elem_s;
        acc_s       = 1'b1;
        i_s         = adv_i_s;
        j_s         = adv_j_s;
        state_s     = adv_done_s ? fin_state_s : S_RD;
      end
`else
      S_WRITE: begin
        if (in_bounds_s) begin
          mem_write_s = 1'b1;
          mem_addr_s  = addr_full_s[ADDRESS_SIZE-1:0];
          mem_din_s   = elem_s;
          i_s         = adv_i_s;
          j_s         = adv_j_s;
          state_s     = adv_done_s ? fin_state_s : S_WRITE;
        end else if (last_r) begin
          // Only (0,0) can be out of bounds here: leave without touching C.
          mem_write_s = 1'b1;
          mem_addr_s  = ADDRESS_SIZE'(STATUS_ADDR);
          mem_din_s   = 32'h0000_0002;
          state_s     = S_DONE;
        end else begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = S_IDLE;
        end
      end
`endif
      S_STATUS: begin
        mem_write_s = 1'b1;
        mem_addr_s  = ADDRESS_SIZE'(STATUS_ADDR);
        mem_din_s   = 32'h0000_0002;
        state_s     = S_DONE;
      end
      S_DONE: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State, position counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      i_r         <= 2'd0;
      j_r         <= 2'd0;
      tile_ack_r  <= 1'b0;
      mem_addr_r  <= '0;
      mem_din_r   <= 32'd0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      i_r         <= i_s;
      j_r         <= j_s;
      tile_ack_r  <= tile_ack_s;
      mem_addr_r  <= mem_addr_s;
      mem_din_r   <= mem_din_s;
      mem_read_r  <= mem_read_s;
      mem_write_r <= mem_write_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  // Tile and dimension capture; held for the whole tile.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tile_r  <= 512'd0;
      row_r   <= 8'd0;
      col_r   <= 8'd0;
      nrows_r <= 8'd0;
      ncols_r <= 8'd0;
      last_r  <= 1'b0;
    end else if (cap_s) begin
      tile_r  <= tile_data;
      row_r   <= tile_row_index;
      col_r   <= tile_col_index;
      nrows_r <= C_row_size;
      ncols_r <= C_column_size;
      last_r  <= last_tile;
    end else begin
      tile_r  <= tile_r;
      last_r  <= last_r;
    end
  end

`ifdef ACCUMULATE_EN
  // Marks a write whose data is the read-back value plus the tile element.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r <= 1'b0;
    end else begin
      acc_r <= acc_s;
    end
  end

  // The read data arrives in the same cycle the write is presented.
  assign mem_Din = acc_r ? (mem_Dout + mem_din_r) : mem_din_r;
`else
  logic dout_unused_s;
  assign dout_unused_s = ^mem_Dout;
  assign mem_Din       = mem_din_r;
`endif

  assign tile_ack  = tile_ack_r;
  assign mem_addr  = mem_addr_r;
  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
